// File: rtl/mul_div_unit.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply and 32-step restoring divide.
// Latency: T+33 iterative, T+1 for div-by-zero/overflow and for multiplies under MULDIV_FAST_MUL_EN.
// Backpressure: busy stalls issue while iterating; start in RUN is ignored; clear/rst_n abort.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [4:0]  rdAddrIn,
  input  logic        clear,
  output logic        busy,
  output logic        resultValid,
  output logic [31:0] result,
  output logic [4:0]  rdAddrOut
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [5:0]  iterCnt;
  logic [63:0] accQ;
  logic [63:0] opAQ;
  logic [31:0] opBQ;
  logic [2:0]  funct3Q;
  logic [4:0]  tagQ;
  logic        negQuoQ;
  logic        negRemQ;

  logic        isDiv, op1Signed, op2Signed, divZero, divOvf, fastMul, quick, accept, iterStart;
  logic [32:0] op1Ext;
  logic [31:0] mag1, mag2, quickResult;

  assign isDiv     = funct3[2];
  assign op1Signed = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
  assign op2Signed = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
  assign op1Ext    = {op1Signed & op1[31], op1};
  assign mag1      = (op1Signed && op1[31]) ? -op1 : op1;
  assign mag2      = (op2Signed && op2[31]) ? -op2 : op2;
  assign divZero   = isDiv && (op2 == 32'd0);
  assign divOvf    = isDiv && !funct3[0] && (op1 == 32'h8000_0000) && (op2 == 32'hFFFF_FFFF);

`ifdef MULDIV_FAST_MUL_EN
  // Both operands extended to 64 bits so a plain modular multiply gives the exact signed product.
  logic [63:0] fastProd;
  assign fastProd = {{31{op1Ext[32]}}, op1Ext} * {{32{op2Signed & op2[31]}}, op2};
  assign fastMul  = !isDiv;
`else
  assign fastMul  = 1'b0;
`endif

  always_comb begin
    quickResult = 32'd0;
    if (divZero)
      quickResult = funct3[1] ? op1 : 32'hFFFF_FFFF;
    else if (divOvf)
      quickResult = funct3[1] ? 32'd0 : 32'h8000_0000;
`ifdef MULDIV_FAST_MUL_EN
    else if (fastMul)
      quickResult = (funct3[1:0] == 2'd0) ? fastProd[31:0] : fastProd[63:32];
`endif
  end

  assign quick       = divZero | divOvf | fastMul;
  assign accept      = rst_n & start & ~clear & (state != RUN);
  assign iterStart   = accept & ~quick;
  assign busy        = iterStart | (state == RUN);
  assign resultValid = (state == DONE);

  logic        lastIter, divOk;
  logic [63:0] mulAddend, mulNext;
  logic [32:0] divShift, divRem;
  logic [33:0] divDiff;
  logic [31:0] quoNext, mulRes, divRes;

  assign lastIter  = (iterCnt == 6'd31);
  assign mulAddend = opBQ[0] ? opAQ : 64'd0;
  // MULH multiplier bit 31 is the sign bit and weighs -2^31, so the final step subtracts.
  assign mulNext   = (lastIter && funct3Q == 3'd1) ? accQ - mulAddend : accQ + mulAddend;
  assign divShift  = {accQ[31:0], opBQ[31]};
  assign divDiff   = {1'b0, divShift} - {2'b00, opAQ[31:0]};
  assign divOk     = ~divDiff[33];
  assign divRem    = divOk ? divDiff[32:0] : divShift;
  assign quoNext   = {opBQ[30:0], divOk};
  assign mulRes    = (funct3Q[1:0] == 2'd0) ? mulNext[31:0] : mulNext[63:32];
  assign divRes    = funct3Q[1] ? (negRemQ ? -divRem[31:0] : divRem[31:0])
                                : (negQuoQ ? -quoNext : quoNext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      iterCnt   <= 6'd0;
      accQ      <= 64'd0;
      opAQ      <= 64'd0;
      opBQ      <= 32'd0;
      funct3Q   <= 3'd0;
      tagQ      <= 5'd0;
      negQuoQ   <= 1'b0;
      negRemQ   <= 1'b0;
      result    <= 32'd0;
      rdAddrOut <= 5'd0;
    end else if (clear) begin
      state <= IDLE;
    end else if (accept && quick) begin
      state     <= DONE;
      iterCnt   <= 6'd0;
      result    <= quickResult;
      rdAddrOut <= rdAddrIn;
    end else if (iterStart) begin
      state   <= RUN;
      iterCnt <= 6'd0;
      funct3Q <= funct3;
      tagQ    <= rdAddrIn;
      accQ    <= 64'd0;
      negQuoQ <= op2Signed & (op1[31] ^ op2[31]);
      negRemQ <= op1Signed & op1[31];
      if (isDiv) begin
        opAQ <= {32'd0, mag2};
        opBQ <= mag1;
      end else begin
        opAQ <= {{31{op1Ext[32]}}, op1Ext};
        opBQ <= op2;
      end
    end else if (state == RUN) begin
      iterCnt <= iterCnt + 6'd1;
      if (funct3Q[2]) begin
        accQ <= {31'd0, divRem};
        opBQ <= quoNext;
      end else begin
        accQ <= mulNext;
        opAQ <= {opAQ[62:0], 1'b0};
        opBQ <= {1'b0, opBQ[31:1]};
      end
      if (lastIter) begin
        state     <= DONE;
        result    <= funct3Q[2] ? divRes : mulRes;
        rdAddrOut <= tagQ;
      end
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: spec vector table, randomized ops vs. arithmetic model,
// and hand sequences for clear, reset, back-to-back and clear/start priority.
module tb_mul_div_unit;
  logic        clk = 1'b0;
  logic        rst_n, start, clear, busy, resultValid;
  logic [2:0]  funct3;
  logic [31:0] op1, op2, result;
  logic [4:0]  rdAddrIn, rdAddrOut;

  int passCnt = 0;
  int totalCnt = 0;
  logic [31:0] lastRes = 32'd0;

  always #5 clk = ~clk;

  mul_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3), .op1(op1), .op2(op2),
    .rdAddrIn(rdAddrIn), .clear(clear), .busy(busy), .resultValid(resultValid),
    .result(result), .rdAddrOut(rdAddrOut)
  );

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit and 32-bit arithmetic on the architectural definitions.
  function automatic logic [31:0] refOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    p = 64'd0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int expLat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2]) begin
      if (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
      return 33;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  function automatic vec_t mkVec(input string n, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] e);
    vec_t v;
    v.name = n; v.f = f; v.a = a; v.b = b; v.exp = e;
    return v;
  endfunction

  task automatic runOp(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    int lat, want;
    logic [4:0] tag;
    logic busyBad;
    want = expLat(f, a, b);
    tag = 5'($urandom);
    start = 1'b1; funct3 = f; op1 = a; op2 = b; rdAddrIn = tag;
    @(negedge clk);
    check({name, " busy@T"}, 32'(busy), 32'(want > 1));
    cyc();
    start = 1'b0; funct3 = 3'($urandom); op1 = $urandom; op2 = $urandom; rdAddrIn = 5'($urandom);
    lat = 0;
    busyBad = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (busy !== ((want > 1) && (k < want))) busyBad = 1'b1;
      if (resultValid === 1'b1) begin lat = k; break; end
      cyc();
    end
    check({name, " latency"}, 32'(lat), 32'(want));
    check({name, " result"}, result, exp);
    check({name, " tag"}, 32'(rdAddrOut), 32'(tag));
    check({name, " busy profile"}, 32'(busyBad), 32'd0);
    cyc();
    @(negedge clk);
    check({name, " valid drop"}, 32'(resultValid), 32'd0);
    check({name, " result hold"}, result, exp);
    lastRes = exp;
    cyc();
  endtask

  vec_t vecs[14];

  initial begin
    logic [2:0]  f, fr;
    logic [31:0] a, b;
    int lat;
    logic sawValid;

    vecs[0]  = mkVec("MUL 7*-6",        3'd0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6);
    vecs[1]  = mkVec("DIV -7/2",        3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    vecs[2]  = mkVec("REM -7%2",        3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    vecs[3]  = mkVec("DIVU by 0",       3'd5, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF);
    vecs[4]  = mkVec("REMU by 0",       3'd7, 32'h0000_1234, 32'd0,         32'h0000_1234);
    vecs[5]  = mkVec("DIV overflow",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    vecs[6]  = mkVec("REM overflow",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    vecs[7]  = mkVec("MULHU max",       3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    vecs[8]  = mkVec("MULH minsq",      3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    vecs[9]  = mkVec("MULHSU -1*max",   3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    vecs[10] = mkVec("DIV by 0",        3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF);
    vecs[11] = mkVec("REM -5 by 0",     3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB);
    vecs[12] = mkVec("DIV min/3",       3'd4, 32'h8000_0000, 32'd3,         32'hD555_5556);
    vecs[13] = mkVec("REM min%3",       3'd6, 32'h8000_0000, 32'd3,         32'hFFFF_FFFE);

    // Reset state, with start held high to show busy stays low during reset.
    rst_n = 1'b0; start = 1'b1; clear = 1'b0; funct3 = 3'd0; op1 = 32'd9; op2 = 32'd9; rdAddrIn = 5'd1;
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset valid", 32'(resultValid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset tag", 32'(rdAddrOut), 32'd0);
    cyc();
    start = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    @(negedge clk);
    check("post-reset valid", 32'(resultValid), 32'd0);
    cyc();

    for (int i = 0; i < 14; i++)
      runOp(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp);

    for (int i = 0; i < 30; i++) begin
      f = 3'($urandom);
      a = $urandom;
      b = $urandom;
      fr = 3'($urandom);
      if (fr == 3'd0) b = 32'd0;
      else if (fr == 3'd1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (fr == 3'd2) b = 32'($urandom_range(1, 20));
      runOp("rand", f, a, b, refOp(f, a, b));
    end

    // Clear mid-DIVU at T+10; a start at T+5 must be ignored.
    start = 1'b1; funct3 = 3'd5; op1 = 32'd1000; op2 = 32'd7; rdAddrIn = 5'd4;
    @(negedge clk);
    check("clr busy@T", 32'(busy), 32'd1);
    sawValid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      cyc();
      start = (k == 5);
      funct3 = 3'd0; op1 = 32'd3; op2 = 32'd3;
      clear = (k == 10);
      @(negedge clk);
      if (k == 6) check("clr ignored start busy", 32'(busy), 32'd1);
      if (k == 11) check("clr busy@T+11", 32'(busy), 32'd0);
      if (resultValid === 1'b1) sawValid = 1'b1;
    end
    check("clr no valid", 32'(sawValid), 32'd0);
    check("clr result held", result, lastRes);
    cyc();
    start = 1'b0; clear = 1'b0;

    // Clear beats a same-cycle start.
    start = 1'b1; clear = 1'b1; funct3 = 3'd5; op1 = 32'd10; op2 = 32'd3;
    @(negedge clk);
    check("prio busy", 32'(busy), 32'd0);
    cyc();
    start = 1'b0; clear = 1'b0;
    sawValid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (resultValid === 1'b1) sawValid = 1'b1;
      cyc();
    end
    check("prio no valid", 32'(sawValid), 32'd0);

    // Back-to-back: new start accepted in the DONE cycle of a divide-by-zero.
    start = 1'b1; funct3 = 3'd5; op1 = 32'h1234; op2 = 32'd0; rdAddrIn = 5'd3;
    @(negedge clk);
    check("b2b div0 busy@T", 32'(busy), 32'd0);
    cyc();
    funct3 = 3'd0; op1 = 32'd7; op2 = 32'hFFFF_FFFA; rdAddrIn = 5'd9;
    @(negedge clk);
    check("b2b first valid", 32'(resultValid), 32'd1);
    check("b2b first result", result, 32'hFFFF_FFFF);
    check("b2b second busy", 32'(busy), 32'(expLat(3'd0, 32'd7, 32'hFFFF_FFFA) > 1));
    cyc();
    start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (resultValid === 1'b1) begin lat = k; break; end
      cyc();
    end
    check("b2b second latency", 32'(lat), 32'(expLat(3'd0, 32'd7, 32'hFFFF_FFFA)));
    check("b2b second result", result, 32'hFFFF_FFD6);
    check("b2b second tag", 32'(rdAddrOut), 32'd9);
    lastRes = 32'hFFFF_FFD6;
    cyc();
    cyc();

    // Reset asserted at T+15 of a long op: outputs drop at once, no result after release.
`ifdef MULDIV_FAST_MUL_EN
    start = 1'b1; funct3 = 3'd5; op1 = 32'hFFFF_FFFF; op2 = 32'd3; rdAddrIn = 5'd7;
`else
    start = 1'b1; funct3 = 3'd3; op1 = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF; rdAddrIn = 5'd7;
`endif
    for (int k = 1; k <= 15; k++) begin
      cyc();
      start = 1'b0;
    end
    @(negedge clk);
    check("rst mid busy before", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst mid busy", 32'(busy), 32'd0);
    check("rst mid valid", 32'(resultValid), 32'd0);
    check("rst mid result", result, 32'd0);
    check("rst mid tag", 32'(rdAddrOut), 32'd0);
    cyc();
    rst_n = 1'b1;
    sawValid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (resultValid === 1'b1 || busy === 1'b1) sawValid = 1'b1;
      cyc();
    end
    check("rst no valid after release", 32'(sawValid), 32'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passCnt, totalCnt);
    $fatal(1);
  end
endmodule
